// File: rtl/draw_arbiter.sv
// Two-requester round-robin arbiter feeding a single line-draw engine.
// Latches the winner's endpoints, runs a per-grant watchdog, pulses ack on exit.
module draw_arbiter #(
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req0,
   input  logic [31:0] coord0,
   input  logic        req1,
   input  logic [31:0] coord1,
   input  logic        draw_done,
   output logic        draw_en,
   output logic [7:0]  x0,
   output logic [7:0]  y0,
   output logic [7:0]  x1,
   output logic [7:0]  y1,
   output logic        ack0,
   output logic        ack1,
   output logic        owner,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAW,
      S_GAP,
      S_ABORT
   } state_t;

   // Last watchdog value a line may reach before it is aborted.
   localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_coord;
   logic        r_owner;
   logic        r_last_owner;
   logic [15:0] r_cnt;

   logic        w_grant;
   logic        w_grant_id;
   logic [1:0]  w_req;
   logic        w_in_draw;
   logic        w_acking;

   assign w_req = {req1, req0};

   // Next-state: IDLE arbitrates, DRAW waits for done or watchdog.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_grant_id  = r_owner;
      unique case (r_state)
         S_IDLE: begin
            if (w_req != 2'b00) begin
               w_grant     = 1'b1;
               w_state_nxt = S_DRAW;
               if (w_req == 2'b11) begin
                  w_grant_id = ~r_last_owner;
               end else begin
                  w_grant_id = w_req[1];
               end
            end
         end
         S_DRAW: begin
            // Completion wins over a coincident watchdog expiry.
            if (draw_done) begin
               w_state_nxt = S_GAP;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = S_ABORT;
            end
         end
         S_GAP: begin
            w_state_nxt = S_IDLE;
         end
         S_ABORT: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant latch: endpoints and owner are captured once, on the grant edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_coord <= 32'd0;
         r_owner <= 1'b0;
      end else if (w_grant) begin
         r_coord <= w_grant_id ? coord1 : coord0;
         r_owner <= w_grant_id;
      end
   end

   // Watchdog: counts DRAW cycles, cleared on grant and everywhere else.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cnt <= 16'd0;
      end else if (w_grant) begin
         r_cnt <= 16'd0;
      end else if (r_state == S_DRAW) begin
         r_cnt <= r_cnt + 16'd1;
      end else begin
         r_cnt <= 16'd0;
      end
   end

   // Round-robin memory: reset favours requester 0 on the first tie.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_last_owner <= 1'b1;
      end else if (w_acking) begin
         r_last_owner <= r_owner;
      end
   end

   assign w_in_draw = (r_state == S_DRAW);
   assign w_acking  = (r_state == S_GAP) || (r_state == S_ABORT);

   assign draw_en     = w_in_draw;
   assign x0          = w_in_draw ? r_coord[7:0]   : 8'd0;
   assign y0          = w_in_draw ? r_coord[15:8]  : 8'd0;
   assign x1          = w_in_draw ? r_coord[23:16] : 8'd0;
   assign y1          = w_in_draw ? r_coord[31:24] : 8'd0;
   assign ack0        = w_acking & ~r_owner;
   assign ack1        = w_acking & r_owner;
   assign owner       = r_owner;
   assign busy        = (r_state != S_IDLE);
   assign timeout_err = (r_state == S_ABORT);

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a line-level behavioural model.
module tb_draw_arbiter;

   localparam int T = 8;

   logic        clk;
   logic        n_rst;
   logic        req0;
   logic [31:0] coord0;
   logic        req1;
   logic [31:0] coord1;
   logic        draw_done;
   logic        draw_en;
   logic [7:0]  x0;
   logic [7:0]  y0;
   logic [7:0]  x1;
   logic [7:0]  y1;
   logic        ack0;
   logic        ack1;
   logic        owner;
   logic        busy;
   logic        timeout_err;

   int n_cmp = 0;
   int n_bad = 0;

   draw_arbiter #(.TIMEOUT_CYC(T)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .req0(req0),
      .coord0(coord0),
      .req1(req1),
      .coord1(coord1),
      .draw_done(draw_done),
      .draw_en(draw_en),
      .x0(x0),
      .y0(y0),
      .x1(x1),
      .y1(y1),
      .ack0(ack0),
      .ack1(ack1),
      .owner(owner),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Line-level model: a line is either being drawn (with an age in
   // cycles), or finished and awaiting its one ack cycle, or absent.
   logic        m_active;
   logic        m_owner;
   logic [31:0] m_coord;
   int          m_age;
   int          m_ackk;
   logic        m_last;
   logic        m_pick;

   assign m_pick = (req0 && req1) ? ~m_last : req1;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_active <= 1'b0;
         m_owner  <= 1'b0;
         m_coord  <= 32'd0;
         m_age    <= 0;
         m_ackk   <= 0;
         m_last   <= 1'b1;
      end else if (m_ackk != 0) begin
         m_ackk <= 0;
         m_last <= m_owner;
      end else if (m_active) begin
         m_age <= m_age + 1;
         if (draw_done) begin
            m_active <= 1'b0;
            m_ackk   <= 1;
         end else if (m_age + 1 == T) begin
            m_active <= 1'b0;
            m_ackk   <= 2;
         end
      end else if (req0 || req1) begin
         m_owner  <= m_pick;
         m_coord  <= m_pick ? coord1 : coord0;
         m_active <= 1'b1;
         m_age    <= 0;
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      check("draw_en", draw_en, m_active);
      check("x0", x0, m_active ? m_coord[7:0] : 8'd0);
      check("y0", y0, m_active ? m_coord[15:8] : 8'd0);
      check("x1", x1, m_active ? m_coord[23:16] : 8'd0);
      check("y1", y1, m_active ? m_coord[31:24] : 8'd0);
      check("ack0", ack0, (m_ackk != 0) && !m_owner);
      check("ack1", ack1, (m_ackk != 0) && m_owner);
      check("owner", owner, m_owner);
      check("busy", busy, m_active || (m_ackk != 0));
      check("timeout_err", timeout_err, m_ackk == 2);
      check("ack_excl", ack0 & ack1, 1'b0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int   cnt;
   int   a0;
   int   a1;
   bit   got;
   bit   prev_en;
   logic owners[$];

   initial begin
      n_rst     = 1'b0;
      req0      = 1'b0;
      req1      = 1'b0;
      coord0    = 32'd0;
      coord1    = 32'd0;
      draw_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_draw_en", draw_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_x0", x0, 8'd0);
      n_rst = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_ack0", ack0, 1'b0);

      // Single requester, done after 5 draw cycles, coords changed mid-line.
      req0   = 1'b1;
      coord0 = 32'h40302010;
      @(negedge clk);
      check("t036_draw_en", draw_en, 1'b1);
      check("t036_x0", x0, 8'h10);
      check("t036_y0", y0, 8'h20);
      check("t036_x1", x1, 8'h30);
      check("t036_y1", y1, 8'h40);
      coord0 = 32'hAABBCCDD;
      repeat (4) begin
         @(negedge clk);
         check("t036_hold_x0", x0, 8'h10);
         check("t036_hold_y1", y1, 8'h40);
      end
      draw_done = 1'b1;
      @(negedge clk);
      draw_done = 1'b0;
      check("t036_ack0", ack0, 1'b1);
      check("t036_en_low", draw_en, 1'b0);
      req0 = 1'b0;
      @(negedge clk);
      check("t036_idle", busy, 1'b0);

      // Tie from reset: requester 0 then requester 1.
      #2 n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      req0  = 1'b1;
      req1  = 1'b1;
      a0 = 0;
      a1 = 0;
      prev_en = 1'b0;
      owners.delete();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (draw_en && !prev_en) owners.push_back(owner);
         prev_en   = draw_en;
         draw_done = draw_en;
         if (ack0) begin a0++; req0 = 1'b0; end
         if (ack1) begin a1++; req1 = 1'b0; end
         if (a0 + a1 >= 2 && !busy) break;
      end
      draw_done = 1'b0;
      check("t037_grants", owners.size(), 2);
      if (owners.size() == 2) begin
         check("t037_first", owners[0], 1'b0);
         check("t037_second", owners[1], 1'b1);
      end
      check("t037_ack0_cnt", a0, 1);
      check("t037_ack1_cnt", a1, 1);

      // Watchdog abort.
      req1 = 1'b1;
      cnt  = 0;
      got  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (draw_en) cnt++;
         if (ack1) begin
            got = 1'b1;
            check("t038_terr", timeout_err, 1'b1);
            req1 = 1'b0;
            break;
         end
      end
      check("t038_ack_seen", got, 1'b1);
      check("t038_en_cycles", cnt, T);
      @(negedge clk);
      check("t038_idle", busy, 1'b0);
      check("t038_terr_low", timeout_err, 1'b0);

      // Done coincident with the last watchdog cycle.
      req0 = 1'b1;
      cnt  = 0;
      got  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         draw_done = 1'b0;
         if (draw_en) begin
            cnt++;
            if (cnt == T) draw_done = 1'b1;
         end
         if (ack0) begin
            got = 1'b1;
            check("t039_terr", timeout_err, 1'b0);
            req0 = 1'b0;
            break;
         end
      end
      draw_done = 1'b0;
      check("t039_ack_seen", got, 1'b1);
      check("t039_en_cycles", cnt, T);

      // Reset mid-line, then a tie must go to requester 0.
      @(negedge clk);
      req0   = 1'b1;
      coord0 = 32'h11223344;
      @(negedge clk);
      check("t040_en", draw_en, 1'b1);
      @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      check("t040_rst_en", draw_en, 1'b0);
      check("t040_rst_ack", ack0, 1'b0);
      check("t040_rst_terr", timeout_err, 1'b0);
      req0 = 1'b0;
      @(negedge clk);
      check("t040_rst_ack2", ack0, 1'b0);
      n_rst = 1'b1;
      req0  = 1'b1;
      req1  = 1'b1;
      @(negedge clk);
      check("t040_tie_en", draw_en, 1'b1);
      check("t040_tie_owner", owner, 1'b0);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (ack0) req0 = 1'b0;
         else if (!req0 && $urandom_range(3) == 0) req0 = 1'b1;
         if (ack1) req1 = 1'b0;
         else if (!req1 && $urandom_range(3) == 0) req1 = 1'b1;
         if ($urandom_range(3) == 0) coord0 = $urandom;
         if ($urandom_range(3) == 0) coord1 = $urandom;
         draw_done = ($urandom_range(9) == 0);
         if ($urandom_range(599) == 0) begin
            #2 n_rst = 1'b0;
            req0 = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
            n_rst = 1'b1;
         end
      end
      req0      = 1'b0;
      req1      = 1'b0;
      draw_done = 1'b0;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
